// File: rtl/popcount20_sched_pkg.sv
// Shared types, widths and the clamping adder for the popcount20 neuron sequencer.
// Imported by the accumulator and the top-level sequencer.
package popcount20_sched_pkg;

    localparam int CHUNK_W = 20;
    localparam int PC_W    = 5;
    localparam int CNT_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_POS  = 3'd2,
        ST_NEG  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Adds two values and clamps the result to the signed range of a w-bit word.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] s;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        s  = a + b;
        if (s > hi) begin
            sat_add = hi;
        end else if (s < lo) begin
            sat_add = lo;
        end else begin
            sat_add = s;
        end
    endfunction

endpackage

// File: rtl/popcount20_sat_acc.sv
// Signed saturating accumulator: clear, add or subtract a popcount each cycle.
// acc_next exposes the value the register takes at the coming edge.
module popcount20_sat_acc
    import popcount20_sched_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    add,
    input  logic                    sub,
    input  logic [PC_W-1:0]         val,
    output logic signed [ACC_W-1:0] acc_next
);

    logic signed [ACC_W-1:0] acc;
    logic signed [31:0]      delta;
    logic signed [31:0]      sum_wide;

    // Select the signed increment and clamp the updated sum.
    always_comb begin
        delta    = 32'sd0;
        sum_wide = 32'sd0;
        if (add) begin
            delta = $signed({27'd0, val});
        end else if (sub) begin
            delta = -$signed({27'd0, val});
        end else begin
            delta = 32'sd0;
        end
        sum_wide = sat_add(32'(acc), delta, ACC_W);
        if (clr) begin
            acc_next = '0;
        end else begin
            acc_next = sum_wide[ACC_W-1:0];
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/popcount20_neuron_sched.sv
// Ternary-neuron sequencer: streams pos/neg chunk masks through an external
// popcount20 unit and reports a saturated signed sum plus a threshold-fire bit.
module popcount20_neuron_sched
    import popcount20_sched_pkg::*;
#(
    parameter int CHUNKS = 4,
    parameter int ACC_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [ACC_W-1:0] thr,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CHUNK_W-1:0]      in_pos,
    input  logic [CHUNK_W-1:0]      in_neg,
    output logic [CHUNK_W-1:0]      pc_in,
    input  logic [PC_W-1:0]         pc_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_fire
);

    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CHUNK_W-1:0]      neg_r;
    logic signed [ACC_W-1:0] thr_r;
    logic signed [ACC_W-1:0] acc_next;
    logic                    acc_clr;
    logic                    acc_add;
    logic                    acc_sub;

    // Accumulator controls follow the current state; pc_out is used as-is.
    always_comb begin
        acc_clr = 1'b0;
        acc_add = 1'b0;
        acc_sub = 1'b0;
        case (state)
            ST_IDLE: acc_clr = start;
            ST_POS:  acc_add = 1'b1;
            ST_NEG:  acc_sub = 1'b1;
            default: begin
                acc_clr = 1'b0;
                acc_add = 1'b0;
                acc_sub = 1'b0;
            end
        endcase
    end

    popcount20_sat_acc #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (acc_clr),
        .add      (acc_add),
        .sub      (acc_sub),
        .val      (pc_out),
        .acc_next (acc_next)
    );

    // Sequencer FSM; every output is a register set on the transition into its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            neg_r     <= '0;
            thr_r     <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_fire  <= 1'b0;
            pc_in     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        thr_r    <= thr;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        pc_in    <= in_pos;
                        neg_r    <= in_neg;
                        in_ready <= 1'b0;
                        state    <= ST_POS;
                    end
                end
                ST_POS: begin
                    pc_in <= neg_r;
                    state <= ST_NEG;
                end
                ST_NEG: begin
                    pc_in <= '0;
                    cnt   <= cnt + 4'd1;
                    // Final sum is captured from the update happening in this same cycle.
                    if (cnt == LAST_CHUNK) begin
                        out_valid <= 1'b1;
                        out_sum   <= acc_next;
                        out_fire  <= (acc_next >= thr_r);
                        state     <= ST_DONE;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    pc_in     <= '0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
